branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: N, default 8, width of PC, offset and result address.
REQ-002 Parameter: TIMEOUT, default 15, maximum WAIT cycles before the block forces an error result.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: cmp_issue  in  1  compare issued; flag result now outstanding.
REQ-006 Port: flag_we  in  1  comparator result valid this cycle.
REQ-007 Port: flags_in  in  6  comparator flags {gte,gt,lte,lt,neq,eq}, bit0 = eq.
REQ-008 Port: br_valid  in  1  branch request valid.
REQ-009 Port: br_ready  out  1  block can accept a request.
REQ-010 Port: br_cond  in  3  condition code: 0 always, 1 eq, 2 neq, 3 lt, 4 lte, 5 gt, 6 gte, 7 never.
REQ-011 Port: br_pc  in  N  PC of the branch.
REQ-012 Port: br_offset  in  N  two's-complement displacement.
REQ-013 Port: flush  in  1  abort the in-flight branch.
REQ-014 Port: res_valid  out  1  one-cycle result strobe.
REQ-015 Port: res_taken  out  1  branch taken.
REQ-016 Port: res_pc  out  N  next PC.
REQ-017 Port: res_err  out  1  result forced by timeout.

Function
REQ-018 The block SHALL hold a 6-bit flag register, loaded from flags_in on every edge with flag_we=1, regardless of FSM state.
REQ-019 The block SHALL hold a pending bit:
- set on cmp_issue=1
- cleared on flag_we=1 with cmp_issue=0
- cmp_issue and flag_we in the same cycle leave pending=1.
REQ-020 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-021 br_ready SHALL be 1 only in IDLE; a request is accepted on an edge with br_valid=1 and br_ready=1, latching br_cond, br_pc and br_offset.
REQ-022 On accept, the FSM SHALL go to:
- DONE, if pending=0 and flag_we=0 in the accept cycle
- WAIT, otherwise.
REQ-023 In WAIT, the FSM SHALL go to DONE on the first edge with pending=0 and flag_we=0; each other WAIT edge increments a wait counter, cleared on accept.
REQ-024 When the wait counter equals TIMEOUT in WAIT, the next edge SHALL enter DONE with res_err=1, res_taken=0, res_pc=br_pc+1.
REQ-025 In DONE, res_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 While res_valid=1, res_taken SHALL be the flag selected by br_cond (1 for cond 0, 0 for cond 7), evaluated from the flag register in the DONE cycle.
REQ-027 res_pc SHALL be (br_pc+br_offset) mod 2^N when taken, and (br_pc+1) mod 2^N otherwise; wrap-around is silent.
REQ-028 Minimum latency SHALL be one cycle from the accept edge to res_valid high.
REQ-029 flush=1 SHALL force IDLE on the next edge from any state, suppressing res_valid; flush has priority over all other transitions, and the flag register and pending bit are unaffected.
REQ-030 res_taken, res_pc and res_err SHALL hold their last values while res_valid=0.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force: state IDLE, pending=0, flag register 0, wait counter 0, res_valid=0, res_taken=0, res_pc=0, res_err=0.
REQ-032 br_ready SHALL read 1 during and after reset.
REQ-033 Reset mid-WAIT or mid-DONE SHALL discard the request with no res_valid.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- flags eq=1 written, pending=0; branch cond=1, pc=0x10, off=0x05 -> res_valid one cycle after accept, taken=1, res_pc=0x15.
- cond=3 (lt), lt=0, pc=0xFF -> taken=0, res_pc=0x00 (wrap).
- cmp_issue, then branch cond=5, off=0xFE (-2), pc=0x20; flag_we with gt=1 three cycles later -> WAIT, then res_valid with taken=1, res_pc=0x1E.
- pending held, no flag_we -> res_valid after TIMEOUT+1 WAIT cycles, res_err=1, taken=0, res_pc=pc+1.
- flush asserted in WAIT -> no res_valid; br_ready=1 next cycle; flags unchanged.
- rst pulse during WAIT -> all outputs 0 asynchronously; a new request afterwards resolves normally.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver: resolves a conditional branch against comparator flags, waiting for an outstanding compare with a timeout
module branch_resolver #(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmp_issue,
    input  logic         flag_we,
    input  logic [5:0]   flags_in,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [2:0]   br_cond,
    input  logic [N-1:0] br_pc,
    input  logic [N-1:0] br_offset,
    input  logic         flush,
    output logic         res_valid,
    output logic         res_taken,
    output logic [N-1:0] res_pc,
    output logic         res_err
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic           pend_q, pend_d;
    logic [5:0]     flags_q, flags_d;
    logic [2:0]     cond_q, cond_d;
    logic [N-1:0]   pc_q, pc_d, off_q, off_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           taken_q, taken_d, rerr_q, rerr_d;
    logic [N-1:0]   rpc_q, rpc_d;
    logic [7:0]     sel;
    logic           out_taken;
    logic [N-1:0]   out_pc;

    // next-state, operand capture and result formation; the condition table is {never, flags, always}
    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        pc_d      = pc_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        flags_d   = flag_we ? flags_in : flags_q;
        pend_d    = cmp_issue | (pend_q & ~flag_we);
        sel       = {1'b0, flags_q, 1'b1};
        out_taken = ~err_q & sel[cond_q];
        out_pc    = out_taken ? pc_q + off_q : pc_q + N'(1);
        res_valid = (state_q == DONE) & ~flush;
        taken_d   = res_valid ? out_taken : taken_q;
        rpc_d     = res_valid ? out_pc : rpc_q;
        rerr_d    = res_valid ? err_q : rerr_q;
        res_taken = taken_d;
        res_pc    = rpc_d;
        res_err   = rerr_d;
        br_ready  = state_q == IDLE;
        unique case (state_q)
            IDLE: if (br_valid) begin
                cond_d  = br_cond;
                pc_d    = br_pc;
                off_d   = br_offset;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = (pend_q | flag_we) ? WAIT : DONE;
            end
            WAIT: if (!pend_q && !flag_we) begin
                state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT)) begin
                state_d = DONE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // state and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            flags_q <= '0;
            cond_q  <= '0;
            pc_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            taken_q <= 1'b0;
            rpc_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
            pc_q    <= pc_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            taken_q <= taken_d;
            rpc_q   <= rpc_d;
            rerr_q  <= rerr_d;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: vector table plus directed wait, timeout, flush and reset sequences, scoreboard-checked
module tb_branch_resolver;
    logic clk, rst, cmp_issue, flag_we, br_valid, br_ready, flush;
    logic res_valid, res_taken, res_err;
    logic [5:0] flags_in;
    logic [2:0] br_cond;
    logic [7:0] br_pc, br_offset, res_pc;

    typedef struct packed {logic t; logic [7:0] pc; logic e;} exp_t;
    typedef struct {logic [5:0] f; logic [2:0] c; logic [7:0] pc, off; logic t; logic [7:0] r;} vec_t;

    exp_t sb[$];
    exp_t x;
    vec_t v[11];
    int checks = 0, errors = 0;

    branch_resolver #(.N(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .cmp_issue(cmp_issue), .flag_we(flag_we), .flags_in(flags_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
        .br_offset(br_offset), .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
        .res_pc(res_pc), .res_err(res_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    always @(negedge clk) if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_res got res_valid=1 want 0");
        end else begin
            x = sb.pop_front();
            chk("res_taken", {31'b0, res_taken}, {31'b0, x.t});
            chk("res_pc", {24'b0, res_pc}, {24'b0, x.pc});
            chk("res_err", {31'b0, res_err}, {31'b0, x.e});
        end
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task wflags(input logic [5:0] f);
        flag_we = 1; flags_in = f;
        step;
        flag_we = 0;
    endtask

    task issue(input logic [2:0] c, input logic [7:0] pc, input logic [7:0] off,
               input bit push, input logic t, input logic [7:0] r, input logic e);
        chk("br_ready", {31'b0, br_ready}, 1);
        br_valid = 1; br_cond = c; br_pc = pc; br_offset = off;
        if (push) sb.push_back('{t: t, pc: r, e: e});
        step;
        br_valid = 0;
    endtask

    task drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) step;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        v[0]  = '{6'b000001, 3'd1, 8'h10, 8'h05, 1'b1, 8'h15};
        v[1]  = '{6'b000000, 3'd3, 8'hFF, 8'h05, 1'b0, 8'h00};
        v[2]  = '{6'b000000, 3'd0, 8'h30, 8'h10, 1'b1, 8'h40};
        v[3]  = '{6'b111111, 3'd7, 8'h30, 8'h10, 1'b0, 8'h31};
        v[4]  = '{6'b000010, 3'd2, 8'h80, 8'h80, 1'b1, 8'h00};
        v[5]  = '{6'b001000, 3'd4, 8'h40, 8'hF0, 1'b1, 8'h30};
        v[6]  = '{6'b100000, 3'd6, 8'h05, 8'h03, 1'b1, 8'h08};
        v[7]  = '{6'b011111, 3'd6, 8'h05, 8'h03, 1'b0, 8'h06};
        v[8]  = '{6'b000100, 3'd3, 8'h7F, 8'h01, 1'b1, 8'h80};
        v[9]  = '{6'b010000, 3'd5, 8'h00, 8'h00, 1'b1, 8'h00};
        v[10] = '{6'b110111, 3'd4, 8'hFE, 8'h07, 1'b0, 8'hFF};
        rst = 1; cmp_issue = 0; flag_we = 0; flags_in = 0; br_valid = 0;
        br_cond = 0; br_pc = 0; br_offset = 0; flush = 0;
        #1;
        chk("rst_ready", {31'b0, br_ready}, 1);
        chk("rst_valid", {31'b0, res_valid}, 0);
        chk("rst_pc", {24'b0, res_pc}, 0);
        chk("rst_taken", {31'b0, res_taken}, 0);
        step;
        rst = 0;
        step;

        for (int i = 0; i < 11; i++) begin
            wflags(v[i].f);
            issue(v[i].c, v[i].pc, v[i].off, 1, v[i].t, v[i].r, 1'b0);
            chk("latency", {31'b0, res_valid}, 1);
            drain(4);
            step;
            chk("hold_valid", {31'b0, res_valid}, 0);
            chk("hold_pc", {24'b0, res_pc}, {24'b0, v[i].r});
        end

        cmp_issue = 1; step; cmp_issue = 0;
        issue(3'd5, 8'h20, 8'hFE, 1, 1'b1, 8'h1E, 1'b0);
        chk("wait_valid", {31'b0, res_valid}, 0);
        chk("wait_ready", {31'b0, br_ready}, 0);
        step; step;
        flag_we = 1; flags_in = 6'b010000; step; flag_we = 0;
        drain(5);

        cmp_issue = 1; step; cmp_issue = 0;
        issue(3'd1, 8'h50, 8'h10, 1, 1'b0, 8'h51, 1'b1);
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin step; n++; end
        chk("tmo_latency", n, 16);
        drain(3);
        step;
        chk("tmo_hold_err", {31'b0, res_err}, 1);
        wflags(6'b000000);
        wflags(6'b000001);
        issue(3'd1, 8'h02, 8'h02, 1, 1'b1, 8'h04, 1'b0);
        drain(4);

        flag_we = 1; flags_in = 6'b000001;
        issue(3'd2, 8'h70, 8'h01, 0, 1'b0, 8'h00, 1'b0);
        flag_we = 0;
        chk("flush_wait", {31'b0, br_ready}, 0);
        flush = 1; step; flush = 0;
        chk("flush_ready", {31'b0, br_ready}, 1);
        chk("flush_valid", {31'b0, res_valid}, 0);
        step;
        issue(3'd1, 8'h10, 8'h01, 1, 1'b1, 8'h11, 1'b0);
        drain(4);

        cmp_issue = 1; step; cmp_issue = 0;
        issue(3'd1, 8'h60, 8'h02, 0, 1'b0, 8'h00, 1'b0);
        step;
        #2 rst = 1;
        #1;
        chk("arst_valid", {31'b0, res_valid}, 0);
        chk("arst_taken", {31'b0, res_taken}, 0);
        chk("arst_pc", {24'b0, res_pc}, 0);
        chk("arst_err", {31'b0, res_err}, 0);
        chk("arst_ready", {31'b0, br_ready}, 1);
        step;
        rst = 0;
        step;
        issue(3'd0, 8'h60, 8'h02, 1, 1'b1, 8'h62, 1'b0);
        chk("post_rst_latency", {31'b0, res_valid}, 1);
        drain(4);
        repeat (3) step;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
